// File: rtl/fetch_seq.sv
// Instruction fetch/sequencing stage: fetches over req/ack into the IR, holds it
// through execute, and resolves JMP/BRC/BRZ into the program counter.
//
// state  | meaning
// FETCH  | request imem[pc], wait for ack, load IR
// DECODE | IR visible to control unit, no request, no execute
// EXEC   | datapath acts; leave and update pc on exec_ready_i
module fetch_seq #(
    parameter int                ADDR_W   = 8,
    parameter int                OPND_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                imem_req_o,
    output logic [ADDR_W-1:0]   imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [OPND_W+3:0]   imem_data_i,
    output logic [3:0]          op_o,
    output logic [OPND_W-1:0]   operand_o,
    output logic                exec_valid_o,
    input  logic                exec_ready_i,
    input  logic                carry_i,
    input  logic                zero_i,
    output logic [ADDR_W-1:0]   pc_o,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    localparam logic [3:0] OP_BRC = 4'b0101;
    localparam logic [3:0] OP_BRZ = 4'b0110;
    localparam logic [3:0] OP_JMP = 4'b0111;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_nxt;
    logic [3:0]          ir_op;
    logic [OPND_W-1:0]   ir_opnd;
    logic                load_ir;
    logic                take_branch;
    logic [ADDR_W-1:0]   target;

    assign target = ADDR_W'(ir_opnd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir_op   <= 4'h0;
            ir_opnd <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (load_ir) begin
                ir_op   <= imem_data_i[OPND_W+3:OPND_W];
                ir_opnd <= imem_data_i[OPND_W-1:0];
            end
        end
    end

    always_comb begin
        take_branch = 1'b0;
        case (ir_op)
            OP_JMP:  take_branch = 1'b1;
            OP_BRC:  take_branch = carry_i;
            OP_BRZ:  take_branch = zero_i;
            default: take_branch = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        load_ir   = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ack_i) begin
                    load_ir   = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                if (exec_ready_i) begin
                    pc_nxt    = take_branch ? target : pc + 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Request is masked during the reset cycle so memory never sees a stale address.
    assign imem_req_o   = (state == FETCH) && !rst_i;
    assign imem_addr_o  = pc;
    assign exec_valid_o = (state == EXEC);
    assign op_o         = ir_op;
    assign operand_o    = ir_opnd;
    assign pc_o         = pc;
    assign state_o      = state;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: handshake timing, PC sequencing, branches,
// stalls, wrap-around and reset during execute.
module tb_fetch_seq;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        imem_req_o;
   logic [7:0]  imem_addr_o;
   logic        imem_ack_i;
   logic [11:0] imem_data_i;
   logic [3:0]  op_o;
   logic [7:0]  operand_o;
   logic        exec_valid_o;
   logic        exec_ready_i;
   logic        carry_i;
   logic        zero_i;
   logic [7:0]  pc_o;
   logic [1:0]  state_o;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_seq #(.ADDR_W(8), .OPND_W(8), .RESET_PC(8'h00)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_data_i  (imem_data_i),
      .op_o         (op_o),
      .operand_o    (operand_o),
      .exec_valid_o (exec_valid_o),
      .exec_ready_i (exec_ready_i),
      .carry_i      (carry_i),
      .zero_i       (zero_i),
      .pc_o         (pc_o),
      .state_o      (state_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_i = 1'b1; imem_ack_i = 1'b0; imem_data_i = 12'h000;
      exec_ready_i = 1'b0; carry_i = 1'b0; zero_i = 1'b0;

      // Reset state
      cyc(); cyc();
      settle();
      chk("rst_state", state_o, 2'd0);
      chk("rst_pc", pc_o, 8'h00);
      chk("rst_op", op_o, 4'h0);
      chk("rst_operand", operand_o, 8'h00);
      chk("rst_exec_valid", exec_valid_o, 1'b0);
      chk("rst_req", imem_req_o, 1'b0);
      rst_i = 1'b0;
      settle();
      chk("post_rst_req", imem_req_o, 1'b1);
      chk("post_rst_addr", imem_addr_o, 8'h00);

      // ADI 0x12, zero-wait ack and ready
      imem_ack_i = 1'b1; imem_data_i = 12'h812; exec_ready_i = 1'b1;
      cyc();
      imem_ack_i = 1'b0; imem_data_i = 12'h000;
      settle();
      chk("adi_dec_state", state_o, 2'd1);
      chk("adi_dec_op", op_o, 4'h8);
      chk("adi_dec_operand", operand_o, 8'h12);
      chk("adi_dec_req", imem_req_o, 1'b0);
      chk("adi_dec_valid", exec_valid_o, 1'b0);
      cyc();
      chk("adi_exec_state", state_o, 2'd2);
      chk("adi_exec_valid", exec_valid_o, 1'b1);
      chk("adi_exec_req", imem_req_o, 1'b0);
      chk("adi_exec_pc", pc_o, 8'h00);
      cyc();
      chk("adi_fetch_state", state_o, 2'd0);
      chk("adi_fetch_valid", exec_valid_o, 1'b0);
      chk("adi_next_pc", pc_o, 8'h01);
      chk("adi_next_addr", imem_addr_o, 8'h01);

      // JMP 0x40
      imem_ack_i = 1'b1; imem_data_i = 12'h740;
      cyc(); imem_ack_i = 1'b0; settle();
      chk("jmp_dec_op", op_o, 4'h7);
      cyc(); cyc();
      chk("jmp_addr", imem_addr_o, 8'h40);

      // BRC 0x20, carry clear -> fall through
      imem_ack_i = 1'b1; imem_data_i = 12'h520;
      cyc(); imem_ack_i = 1'b0;
      cyc(); carry_i = 1'b0;
      cyc();
      chk("brc_nc_pc", pc_o, 8'h41);

      // BRC 0x20, carry set -> taken
      imem_ack_i = 1'b1; imem_data_i = 12'h520;
      cyc(); imem_ack_i = 1'b0;
      cyc(); carry_i = 1'b1;
      cyc(); carry_i = 1'b0;
      chk("brc_c_pc", pc_o, 8'h20);

      // BRZ 0x30, zero set -> taken
      imem_ack_i = 1'b1; imem_data_i = 12'h630;
      cyc(); imem_ack_i = 1'b0;
      cyc(); zero_i = 1'b1;
      cyc(); zero_i = 1'b0;
      chk("brz_z_pc", pc_o, 8'h30);

      // BRZ 0x50, zero clear but carry set -> must fall through
      imem_ack_i = 1'b1; imem_data_i = 12'h650;
      cyc(); imem_ack_i = 1'b0;
      cyc(); carry_i = 1'b1; zero_i = 1'b0;
      cyc(); carry_i = 1'b0;
      chk("brz_nz_pc", pc_o, 8'h31);

      // Ack delayed 3 cycles: request/address held 4 cycles, IR untouched
      imem_data_i = 12'h9AA;
      for (int i = 0; i < 3; i++) begin
         chk("wait_state", state_o, 2'd0);
         chk("wait_req", imem_req_o, 1'b1);
         chk("wait_addr", imem_addr_o, 8'h31);
         chk("wait_op", op_o, 4'h6);
         chk("wait_operand", operand_o, 8'h50);
         cyc();
      end
      chk("ack_cycle_req", imem_req_o, 1'b1);
      chk("ack_cycle_addr", imem_addr_o, 8'h31);
      imem_ack_i = 1'b1; imem_data_i = 12'h055;
      cyc();
      // stray ack during DECODE and EXEC must not reload the IR
      imem_data_i = 12'h9AA;
      settle();
      chk("lda_dec_op", op_o, 4'h0);
      chk("lda_dec_operand", operand_o, 8'h55);
      cyc();
      imem_ack_i = 1'b0; exec_ready_i = 1'b0;
      settle();
      chk("stray_ack_op", op_o, 4'h0);
      chk("stray_ack_operand", operand_o, 8'h55);

      // LDA stalled 5 cycles: exec_valid high 6 cycles
      for (int i = 0; i < 5; i++) begin
         chk("stall_state", state_o, 2'd2);
         chk("stall_valid", exec_valid_o, 1'b1);
         chk("stall_op", op_o, 4'h0);
         chk("stall_pc", pc_o, 8'h31);
         cyc();
      end
      exec_ready_i = 1'b1;
      settle();
      chk("ready_valid", exec_valid_o, 1'b1);
      chk("ready_pc", pc_o, 8'h31);
      cyc();
      chk("lda_next_pc", pc_o, 8'h32);
      chk("lda_next_valid", exec_valid_o, 1'b0);

      // JMP 0xFF then ADD at 0xFF wraps to 0x00
      imem_ack_i = 1'b1; imem_data_i = 12'h7FF;
      cyc(); imem_ack_i = 1'b0;
      cyc(); cyc();
      chk("jmp_ff_pc", pc_o, 8'hFF);
      imem_ack_i = 1'b1; imem_data_i = 12'h901;
      cyc(); imem_ack_i = 1'b0;
      cyc(); cyc();
      chk("wrap_addr", imem_addr_o, 8'h00);

      // ADD at 0x00 moves pc to 0x01, then LDA stalls and reset hits in EXEC
      imem_ack_i = 1'b1; imem_data_i = 12'h900;
      cyc(); imem_ack_i = 1'b0;
      cyc(); cyc();
      chk("add0_pc", pc_o, 8'h01);
      imem_ack_i = 1'b1; imem_data_i = 12'h010;
      cyc(); imem_ack_i = 1'b0;
      cyc(); exec_ready_i = 1'b0;
      cyc();
      chk("pre_rst_state", state_o, 2'd2);
      chk("pre_rst_operand", operand_o, 8'h10);
      rst_i = 1'b1; imem_ack_i = 1'b1; imem_data_i = 12'h7FF;
      settle();
      chk("in_rst_req", imem_req_o, 1'b0);
      cyc();
      chk("exec_rst_state", state_o, 2'd0);
      chk("exec_rst_pc", pc_o, 8'h00);
      chk("exec_rst_op", op_o, 4'h0);
      chk("exec_rst_operand", operand_o, 8'h00);
      chk("exec_rst_valid", exec_valid_o, 1'b0);

      // Late ack after reset is a fresh fetch at RESET_PC
      rst_i = 1'b0;
      settle();
      chk("late_ack_req", imem_req_o, 1'b1);
      chk("late_ack_addr", imem_addr_o, 8'h00);
      cyc();
      imem_ack_i = 1'b0;
      chk("late_ack_state", state_o, 2'd1);
      chk("late_ack_op", op_o, 4'h7);
      chk("late_ack_operand", operand_o, 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
